// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enc_pkg
//  Description : Shared types, widths and the wrap-aware delta helper for the
//                encoder position tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    localparam int POS_W = 19;
    localparam int ABS_W = 32;

    typedef enum logic [0:0] {
        SEED  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // The modulo-2**POS_W subtraction yields the shortest signed step,
    // so crossing the single-turn wrap point is handled implicitly.
    function automatic logic signed [POS_W-1:0] wrap_delta(
        input logic [POS_W-1:0] cur,
        input logic [POS_W-1:0] prev
    );
        return signed'(cur - prev);
    endfunction

endpackage
`default_nettype wire

// File: rtl/encoder_position_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_position_tracker_if
//  Description : Sample input and position/velocity/fault output bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface encoder_position_tracker_if;

    logic [enc_pkg::POS_W-1:0] enc_pos;
    logic                      enc_valid;
    logic                      clear;
    logic [enc_pkg::ABS_W-1:0] pos_out;
    logic [enc_pkg::POS_W-1:0] vel_out;
    logic                      out_valid;
    logic                      jump_err;
    logic                      err_sticky;
    logic                      stale;

    modport master (
        output enc_pos, enc_valid, clear,
        input  pos_out, vel_out, out_valid, jump_err, err_sticky, stale
    );

    modport slave (
        input  enc_pos, enc_valid, clear,
        output pos_out, vel_out, out_valid, jump_err, err_sticky, stale
    );

endinterface
`default_nettype wire

// File: rtl/enc_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : enc_watchdog
//  Description : Counts clk cycles between samples; flags expiry after TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_watchdog #(
    parameter int TIMEOUT = 100000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic kick,
    input  wire logic enable,
    output logic      expired
);

    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Expiry fires on the edge that would complete the TIMEOUT-th idle cycle.
    assign expired = enable && !kick && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!enable || kick || expired) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/encoder_position_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_position_tracker
//  Description : Multi-turn position, velocity and fault tracking from
//                single-turn absolute encoder samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_position_tracker
    import enc_pkg::*;
#(
    parameter int MAX_STEP = 65536,
    parameter int TIMEOUT  = 100000
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    encoder_position_tracker_if.slave  bus
);

    localparam logic [POS_W-1:0] c_max_step = POS_W'(MAX_STEP);

    state_t                   r_state;
    logic [POS_W-1:0]         r_prev;
    logic [ABS_W-1:0]         r_abs;
    logic [POS_W-1:0]         r_vel;
    logic                     r_out_valid;
    logic                     r_jump_err;
    logic                     r_err_sticky;
    logic                     r_stale;
    logic [1:0]               r_rej_cnt;

    logic signed [POS_W-1:0]  w_delta;
    logic [POS_W-1:0]         w_mag;
    logic [ABS_W-1:0]         w_delta_ext;
    logic                     w_accept;
    logic                     w_expired;

    assign w_delta     = wrap_delta(bus.enc_pos, r_prev);
    assign w_delta_ext = {{(ABS_W-POS_W){w_delta[POS_W-1]}}, w_delta};
    // Negating -2**(POS_W-1) leaves it unchanged, and that magnitude already
    // exceeds any legal MAX_STEP, so the most negative delta is always rejected.
    assign w_mag       = w_delta[POS_W-1] ? POS_W'(-w_delta) : POS_W'(w_delta);
    assign w_accept    = (w_mag <= c_max_step);

    enc_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .kick    (bus.enc_valid),
        .enable  (r_state == TRACK),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SEED;
            r_prev       <= '0;
            r_abs        <= '0;
            r_vel        <= '0;
            r_out_valid  <= 1'b0;
            r_jump_err   <= 1'b0;
            r_err_sticky <= 1'b0;
            r_stale      <= 1'b0;
            r_rej_cnt    <= 2'd0;
        end else begin
            r_out_valid <= 1'b0;
            r_jump_err  <= 1'b0;
            if (bus.clear) begin
                r_abs        <= '0;
                r_err_sticky <= 1'b0;
            end
            case (r_state)
                SEED: begin
                    if (bus.enc_valid) begin
                        r_prev      <= bus.enc_pos;
                        r_vel       <= '0;
                        r_out_valid <= 1'b1;
                        r_stale     <= 1'b0;
                        r_rej_cnt   <= 2'd0;
                        r_state     <= TRACK;
                    end
                end
                TRACK: begin
                    if (bus.enc_valid) begin
                        if (bus.clear) begin
                            // Sample alongside clear re-references the zeroed position.
                            r_prev      <= bus.enc_pos;
                            r_vel       <= '0;
                            r_out_valid <= 1'b1;
                            r_rej_cnt   <= 2'd0;
                        end else if (w_accept) begin
                            r_abs       <= r_abs + w_delta_ext;
                            r_prev      <= bus.enc_pos;
                            r_vel       <= w_delta;
                            r_out_valid <= 1'b1;
                            r_rej_cnt   <= 2'd0;
                        end else begin
                            r_jump_err   <= 1'b1;
                            r_err_sticky <= 1'b1;
                            if (r_rej_cnt == 2'd2) begin
                                r_prev    <= bus.enc_pos;
                                r_vel     <= '0;
                                r_rej_cnt <= 2'd0;
                            end else begin
                                r_rej_cnt <= r_rej_cnt + 2'd1;
                            end
                        end
                    end else if (w_expired) begin
                        r_state      <= SEED;
                        r_stale      <= 1'b1;
                        r_err_sticky <= 1'b1;
                        r_rej_cnt    <= 2'd0;
                    end
                end
                default: r_state <= SEED;
            endcase
        end
    end

    assign bus.pos_out    = r_abs;
    assign bus.vel_out    = r_vel;
    assign bus.out_valid  = r_out_valid;
    assign bus.jump_err   = r_jump_err;
    assign bus.err_sticky = r_err_sticky;
    assign bus.stale      = r_stale;

endmodule
`default_nettype wire

// File: tb/tb_encoder_position_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder_position_tracker
//  Description : Directed, self-checking bench with a behavioural reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_position_tracker;

    localparam int c_pos_w    = 19;
    localparam int c_mod      = 1 << c_pos_w;
    localparam int c_half     = 1 << (c_pos_w - 1);
    localparam int c_max_step = 65536;
    localparam int c_timeout  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    encoder_position_tracker_if bus ();

    encoder_position_tracker #(
        .MAX_STEP (c_max_step),
        .TIMEOUT  (c_timeout)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: position/velocity derived from rules on plain integers.
    logic        m_tracking = 1'b0;
    int          m_prev = 0;
    logic [31:0] m_abs = '0;
    logic [18:0] m_vel = '0;
    logic        m_ov = 1'b0, m_je = 1'b0, m_err = 1'b0, m_stale = 1'b0;
    int          m_rejects = 0;
    int          m_idle = 0;
    logic        armed = 1'b0;

    function automatic int shortest_step(input int cur, input int prev);
        int d;
        d = (cur - prev + c_mod) % c_mod;
        if (d >= c_half) d -= c_mod;
        return d;
    endfunction

    task automatic model_seed(input int pos);
        m_prev     = pos;
        m_vel      = '0;
        m_ov       = 1'b1;
        m_stale    = 1'b0;
        m_tracking = 1'b1;
        m_rejects  = 0;
        m_idle     = 0;
    endtask

    task automatic model_cycle(input logic r, input logic v, input int pos, input logic clr);
        int d;
        if (r) begin
            m_tracking = 1'b0; m_prev = 0; m_abs = '0; m_vel = '0;
            m_ov = 1'b0; m_je = 1'b0; m_err = 1'b0; m_stale = 1'b0;
            m_rejects = 0; m_idle = 0;
            return;
        end
        m_ov = 1'b0;
        m_je = 1'b0;
        if (clr) begin
            m_abs = '0;
            m_err = 1'b0;
        end
        if (!m_tracking) begin
            if (v) model_seed(pos);
        end else if (v) begin
            m_idle = 0;
            d = shortest_step(pos, m_prev);
            if (clr) begin
                model_seed(pos);
            end else if (d != -c_half && d <= c_max_step && d >= -c_max_step) begin
                m_abs     = m_abs + 32'(d);
                m_prev    = pos;
                m_vel     = 19'(d);
                m_ov      = 1'b1;
                m_rejects = 0;
            end else begin
                m_je = 1'b1;
                m_err = 1'b1;
                m_rejects++;
                if (m_rejects == 3) begin
                    m_prev = pos;
                    m_vel = '0;
                    m_rejects = 0;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == c_timeout) begin
                m_tracking = 1'b0;
                m_stale    = 1'b1;
                m_err      = 1'b1;
                m_rejects  = 0;
                m_idle     = 0;
            end
        end
    endtask

    // Inputs are held from negedge+1 to the next negedge+1, so at each
    // negedge they still show what the preceding rising edge sampled.
    initial begin
        forever begin
            @(negedge clk);
            model_cycle(rst, bus.enc_valid, int'(bus.enc_pos), bus.clear);
            if (rst) armed = 1'b1;
            if (armed) begin
                chk("cmp_pos_out",    64'(bus.pos_out),    64'(m_abs));
                chk("cmp_vel_out",    64'(bus.vel_out),    64'(m_vel));
                chk("cmp_out_valid",  64'(bus.out_valid),  64'(m_ov));
                chk("cmp_jump_err",   64'(bus.jump_err),   64'(m_je));
                chk("cmp_err_sticky", 64'(bus.err_sticky), 64'(m_err));
                chk("cmp_stale",      64'(bus.stale),      64'(m_stale));
            end
        end
    end

    task automatic step(input logic r, input logic v, input int pos, input logic clr);
        @(negedge clk);
        #1;
        rst           = r;
        bus.enc_valid = v;
        bus.enc_pos   = 19'(pos);
        bus.clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0, 1'b0);
    endtask

    initial begin
        bus.enc_valid = 1'b0;
        bus.enc_pos   = '0;
        bus.clear     = 1'b0;

        // 1: reset state, seed then +10
        do_reset();
        chk("rst_pos", 64'(bus.pos_out), 64'd0);
        chk("rst_flags", 64'({bus.out_valid, bus.jump_err, bus.err_sticky, bus.stale}), 64'd0);
        step(1'b0, 1'b1, 1000, 1'b0);
        chk("t1_seed_ov", 64'(bus.out_valid), 64'd1);
        chk("t1_seed_vel", 64'(bus.vel_out), 64'd0);
        step(1'b0, 1'b1, 1010, 1'b0);
        chk("t1_pos", 64'(bus.pos_out), 64'd10);
        chk("t1_vel", 64'(bus.vel_out), 64'd10);
        chk("t1_ov", 64'(bus.out_valid), 64'd1);

        // 2: wrap in both directions
        do_reset();
        step(1'b0, 1'b1, 524287, 1'b0);
        step(1'b0, 1'b1, 2, 1'b0);
        chk("t2_fwd_vel", 64'(bus.vel_out), 64'd3);
        chk("t2_fwd_pos", 64'(bus.pos_out), 64'd3);
        do_reset();
        step(1'b0, 1'b1, 2, 1'b0);
        step(1'b0, 1'b1, 524287, 1'b0);
        chk("t2_rev_vel", 64'(bus.vel_out), 64'h7FFFD);
        chk("t2_rev_pos", 64'(bus.pos_out), 64'hFFFF_FFFD);

        // 3: rejects and re-seed on the third
        do_reset();
        step(1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b1, 100000, 1'b0);
        chk("t3_je", 64'(bus.jump_err), 64'd1);
        chk("t3_sticky", 64'(bus.err_sticky), 64'd1);
        chk("t3_pos", 64'(bus.pos_out), 64'd0);
        chk("t3_no_ov", 64'(bus.out_valid), 64'd0);
        step(1'b0, 1'b1, 100000, 1'b0);
        step(1'b0, 1'b1, 100000, 1'b0);
        chk("t3_reseed_je", 64'(bus.jump_err), 64'd1);
        chk("t3_reseed_vel", 64'(bus.vel_out), 64'd0);
        step(1'b0, 1'b1, 100005, 1'b0);
        chk("t3_after_pos", 64'(bus.pos_out), 64'd5);

        // 4: timeout and recovery
        do_reset();
        step(1'b0, 1'b1, 100, 1'b0);
        step(1'b0, 1'b1, 150, 1'b0);
        idle(c_timeout - 1);
        chk("t4_not_stale", 64'(bus.stale), 64'd0);
        idle(1);
        chk("t4_stale", 64'(bus.stale), 64'd1);
        chk("t4_pos_held", 64'(bus.pos_out), 64'd50);
        step(1'b0, 1'b1, 5000, 1'b0);
        chk("t4_unstale", 64'(bus.stale), 64'd0);
        chk("t4_vel", 64'(bus.vel_out), 64'd0);
        chk("t4_pos", 64'(bus.pos_out), 64'd50);
        step(1'b0, 1'b1, 5010, 1'b0);
        chk("t4_pos2", 64'(bus.pos_out), 64'd60);

        // 5: clear with a sample, then boundary steps
        do_reset();
        step(1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b1, 500, 1'b0);
        step(1'b0, 1'b1, 300000, 1'b0);
        chk("t5_pre_sticky", 64'(bus.err_sticky), 64'd1);
        step(1'b0, 1'b1, 7, 1'b1);
        chk("t5_clr_pos", 64'(bus.pos_out), 64'd0);
        chk("t5_clr_vel", 64'(bus.vel_out), 64'd0);
        chk("t5_clr_sticky", 64'(bus.err_sticky), 64'd0);
        chk("t5_clr_ov", 64'(bus.out_valid), 64'd1);
        step(1'b0, 1'b1, 9, 1'b0);
        chk("t5_pos", 64'(bus.pos_out), 64'd2);
        step(1'b0, 1'b1, 9 + 65536, 1'b0);
        chk("t5_maxstep_pos", 64'(bus.pos_out), 64'd65538);
        step(1'b0, 1'b1, 9, 1'b0);
        chk("t5_negmax_pos", 64'(bus.pos_out), 64'd2);
        step(1'b0, 1'b1, 9 + 65537, 1'b0);
        chk("t5_over_je", 64'(bus.jump_err), 64'd1);
        step(1'b0, 1'b1, 9 + 262144, 1'b0);
        chk("t5_half_je", 64'(bus.jump_err), 64'd1);
        step(1'b0, 1'b0, 0, 1'b1);
        chk("t5_clear_only", 64'(bus.pos_out), 64'd0);

        // 6: reset with a sample mid-track
        step(1'b0, 1'b1, 12, 1'b0);
        step(1'b1, 1'b1, 20, 1'b0);
        chk("t6_pos", 64'(bus.pos_out), 64'd0);
        chk("t6_vel", 64'(bus.vel_out), 64'd0);
        chk("t6_flags", 64'({bus.out_valid, bus.jump_err, bus.err_sticky, bus.stale}), 64'd0);
        step(1'b0, 1'b1, 30, 1'b0);
        chk("t6_seed_vel", 64'(bus.vel_out), 64'd0);
        step(1'b0, 1'b1, 40, 1'b0);
        chk("t6_pos2", 64'(bus.pos_out), 64'd10);

        idle(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
